// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle MIPS-style control path.
// Contains the 4-bit FSM state encoding, the opcode constants the controller
// dispatches on, and the ALUOp / ALUSrcB / PCSource select codes. The
// datapath and ALU_Control reuse these so every block agrees on encodings.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

   // FSM state encoding; IDLE is 0 so a freshly reset controller reads 0 and
   // ERROR sits at the top of the range, clear of the normal flow.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'h0,
      ST_FETCH  = 4'h1,
      ST_DECODE = 4'h2,
      ST_MEMADR = 4'h3,
      ST_MEMRD  = 4'h4,
      ST_MEMWB  = 4'h5,
      ST_MEMWR  = 4'h6,
      ST_REXEC  = 4'h7,
      ST_RWB    = 4'h8,
      ST_IEXEC  = 4'h9,
      ST_IWB    = 4'hA,
      ST_BRANCH = 4'hB,
      ST_JUMP   = 4'hC,
      ST_ERROR  = 4'hF
   } state_e;

   // Opcode field values (instr[31:26]) recognised by the decoder.
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUOp codes handed to ALU_Control.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Second ALU operand selection.
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Next-PC source selection.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // A completion state is the last cycle of an instruction; leaving one
   // retires the instruction and returns to FETCH or IDLE.
   function automatic logic isCompletion(input state_e s);
      return (s == ST_MEMWB) || (s == ST_MEMWR) || (s == ST_RWB) ||
             (s == ST_IWB)   || (s == ST_BRANCH) || (s == ST_JUMP);
   endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational Moore output decode: maps the registered FSM state to
// every datapath control signal plus the busy/error status flags.
// Ports:
//   state_i        current registered state
//   PCWrite_o ..   single-bit datapath enables/selects
//   ALUSrcB_o      second ALU operand select
//   ALUOp_o        ALU operation class for ALU_Control
//   PCSource_o     next-PC source select
//   busy_o         an instruction is in flight
//   err_o          controller is parked in ERROR
// ---------------------------------------------------------------------------
module mc_ctrl_decode
   import multicycle_control_pkg::*;
(
   input  state_e     state_i,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic       IRWrite_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       RegWrite_o,
   output logic       RegDst_o,
   output logic       MemtoReg_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [1:0] ALUOp_o,
   output logic [1:0] PCSource_o,
   output logic       busy_o,
   output logic       err_o
);

   // Every output starts inactive so IDLE, ERROR and any unused encoding
   // drive nothing; each state then raises only what it needs. Because the
   // per-state assignments never pair PCWrite with PCWriteCond or MemRead
   // with MemWrite, those pairs are mutually exclusive by construction.
   always_comb begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IRWrite_o     = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      RegWrite_o    = 1'b0;
      RegDst_o      = 1'b0;
      MemtoReg_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = SRCB_REG;
      ALUOp_o       = ALUOP_ADD;
      PCSource_o    = PCSRC_ALU;
      busy_o        = 1'b0;
      err_o         = 1'b0;

      case (state_i)
         ST_FETCH: begin
            MemRead_o  = 1'b1;
            IRWrite_o  = 1'b1;
            PCWrite_o  = 1'b1;
            ALUSrcB_o  = SRCB_FOUR;
            ALUOp_o    = ALUOP_ADD;
            PCSource_o = PCSRC_ALU;
         end
         ST_DECODE: begin
            ALUSrcB_o = SRCB_IMM_SH2;
            ALUOp_o   = ALUOP_ADD;
         end
         ST_MEMADR, ST_IEXEC: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_IMM;
            ALUOp_o   = ALUOP_ADD;
         end
         ST_MEMRD: begin
            MemRead_o = 1'b1;
         end
         ST_MEMWB: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = 1'b1;
         end
         ST_MEMWR: begin
            MemWrite_o = 1'b1;
         end
         ST_REXEC: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_REG;
            ALUOp_o   = ALUOP_FUNCT;
         end
         ST_RWB: begin
            RegWrite_o = 1'b1;
            RegDst_o   = 1'b1;
         end
         ST_IWB: begin
            RegWrite_o = 1'b1;
         end
         ST_BRANCH: begin
            ALUSrcA_o     = 1'b1;
            ALUSrcB_o     = SRCB_REG;
            ALUOp_o       = ALUOP_SUB;
            PCWriteCond_o = 1'b1;
            PCSource_o    = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = PCSRC_JUMP;
         end
         default: begin
         end
      endcase

      busy_o = (state_i != ST_IDLE) && (state_i != ST_ERROR);
      err_o  = (state_i == ST_ERROR);
   end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle MIPS subset (lw, sw, R-type,
// addi, beq, j). Holds the state register, next-state logic and a count of
// retired instructions; output decode lives in mc_ctrl_decode.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   start_i        run enable, sampled in IDLE and at instruction boundaries
//   Op_i           opcode field from the instruction register
//   *_o controls   datapath control signals (see mc_ctrl_decode)
//   busy_o, err_o  status flags
//   state_o        current state encoding
//   retired_o      number of completed instructions (wraps silently)
// ---------------------------------------------------------------------------
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [5:0]  Op_i,
   output logic        PCWrite_o,
   output logic        PCWriteCond_o,
   output logic        IRWrite_o,
   output logic        MemRead_o,
   output logic        MemWrite_o,
   output logic        RegWrite_o,
   output logic        RegDst_o,
   output logic        MemtoReg_o,
   output logic        ALUSrcA_o,
   output logic [1:0]  ALUSrcB_o,
   output logic [1:0]  ALUOp_o,
   output logic [1:0]  PCSource_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [3:0]  state_o,
   output logic [31:0] retired_o
);

   state_e      state_q;
   state_e      state_d;
   logic [31:0] retired_q;
   logic [31:0] retired_d;

   // State and retire counter registers. Reset wins over every transition,
   // including one in the middle of an instruction, and returns to IDLE with
   // the counter cleared (which also clears err since it follows the state).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Next-state logic. start_i only matters in IDLE and in the completion
   // states, so dropping it mid-instruction lets the instruction finish.
   // ERROR is sticky; only reset leaves it. Unused encodings fall to ERROR
   // so a corrupted state register cannot wander silently.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = start_i ? ST_FETCH : ST_IDLE;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            case (Op_i)
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_RTYPE:     state_d = ST_REXEC;
               OP_ADDI:      state_d = ST_IEXEC;
               OP_BEQ:       state_d = ST_BRANCH;
               OP_J:         state_d = ST_JUMP;
               default:      state_d = ST_ERROR;
            endcase
         end
         ST_MEMADR: state_d = (Op_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  state_d = ST_MEMWB;
         ST_REXEC:  state_d = ST_RWB;
         ST_IEXEC:  state_d = ST_IWB;
         ST_MEMWB, ST_MEMWR, ST_RWB, ST_IWB, ST_BRANCH, ST_JUMP:
                    state_d = start_i ? ST_FETCH : ST_IDLE;
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_ERROR;
      endcase
   end

   // Every completion state is left on the very next edge, so the counter
   // bumps whenever the current state is a completion state. The add simply
   // rolls over at the top of the 32-bit range.
   always_comb begin
      retired_d = retired_q;
      if (isCompletion(state_q)) begin
         retired_d = retired_q + 32'd1;
      end
   end

   // Moore output decode driven only from the registered state.
   mc_ctrl_decode uDecode (
      .state_i       (state_q),
      .PCWrite_o     (PCWrite_o),
      .PCWriteCond_o (PCWriteCond_o),
      .IRWrite_o     (IRWrite_o),
      .MemRead_o     (MemRead_o),
      .MemWrite_o    (MemWrite_o),
      .RegWrite_o    (RegWrite_o),
      .RegDst_o      (RegDst_o),
      .MemtoReg_o    (MemtoReg_o),
      .ALUSrcA_o     (ALUSrcA_o),
      .ALUSrcB_o     (ALUSrcB_o),
      .ALUOp_o       (ALUOp_o),
      .PCSource_o    (PCSource_o),
      .busy_o        (busy_o),
      .err_o         (err_o)
   );

   assign state_o   = state_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control: walks lw, R-type, beq, sw, addi and
// j instructions, an illegal opcode, reset mid-instruction and a forced
// retire-counter rollover. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  op;
   logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite;
   logic        RegWrite, RegDst, MemtoReg, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic        busy, err;
   logic [3:0]  stateOut;
   logic [31:0] retired;

   int checks   = 0;
   int failures = 0;

   // Control vector packing, MSB first:
   // PCWrite PCWriteCond IRWrite MemRead MemWrite RegWrite RegDst MemtoReg
   // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
   localparam logic [14:0] CTRL_NONE   = 15'b000000000_000000;
   localparam logic [14:0] CTRL_FETCH  = 15'b101100000_010000;
   localparam logic [14:0] CTRL_DECODE = 15'b000000000_110000;
   localparam logic [14:0] CTRL_MEMADR = 15'b000000001_100000;
   localparam logic [14:0] CTRL_MEMRD  = 15'b000100000_000000;
   localparam logic [14:0] CTRL_MEMWB  = 15'b000001010_000000;
   localparam logic [14:0] CTRL_MEMWR  = 15'b000010000_000000;
   localparam logic [14:0] CTRL_REXEC  = 15'b000000001_001000;
   localparam logic [14:0] CTRL_RWB    = 15'b000001100_000000;
   localparam logic [14:0] CTRL_IEXEC  = 15'b000000001_100000;
   localparam logic [14:0] CTRL_IWB    = 15'b000001000_000000;
   localparam logic [14:0] CTRL_BRANCH = 15'b010000001_000101;
   localparam logic [14:0] CTRL_JUMP   = 15'b100000000_000010;

   logic [14:0] ctrlVec;
   assign ctrlVec = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite,
                     RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource};

   multicycle_control dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .Op_i          (op),
      .PCWrite_o     (PCWrite),
      .PCWriteCond_o (PCWriteCond),
      .IRWrite_o     (IRWrite),
      .MemRead_o     (MemRead),
      .MemWrite_o    (MemWrite),
      .RegWrite_o    (RegWrite),
      .RegDst_o      (RegDst),
      .MemtoReg_o    (MemtoReg),
      .ALUSrcA_o     (ALUSrcA),
      .ALUSrcB_o     (ALUSrcB),
      .ALUOp_o       (ALUOp),
      .PCSource_o    (PCSource),
      .busy_o        (busy),
      .err_o         (err),
      .state_o       (stateOut),
      .retired_o     (retired)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at the falling edge so they are stable across the next
   // rising edge.
   task automatic applyStimulus(input logic r, input logic s, input logic [5:0] o);
      rst   = r;
      start = s;
      op    = o;
   endtask

   // Advance one rising edge and return at the following falling edge, where
   // outputs are settled and safe to sample.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [3:0] expState,
                             input logic [14:0] expCtrl);
      checkOutput({tag, "_state"}, {28'd0, stateOut}, {28'd0, expState});
      checkOutput({tag, "_ctrl"}, {17'd0, ctrlVec}, {17'd0, expCtrl});
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 6'b000000);
      @(negedge clk);
      tick();
      tick();

      // Reset state
      checkState("reset", 4'h0, CTRL_NONE);
      checkOutput("reset_retired", retired, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);

      // lw: FETCH DECODE MEMADR MEMRD MEMWB then back to FETCH
      applyStimulus(1'b0, 1'b1, 6'b100011);
      tick(); checkState("lw_fetch", 4'h1, CTRL_FETCH);
      checkOutput("lw_fetch_busy", {31'd0, busy}, 32'd1);
      tick(); checkState("lw_decode", 4'h2, CTRL_DECODE);
      tick(); checkState("lw_memadr", 4'h3, CTRL_MEMADR);
      tick(); checkState("lw_memrd", 4'h4, CTRL_MEMRD);
      tick(); checkState("lw_memwb", 4'h5, CTRL_MEMWB);
      checkOutput("lw_retired_before", retired, 32'd0);
      applyStimulus(1'b0, 1'b1, 6'b000000);
      tick(); checkState("lw_next_fetch", 4'h1, CTRL_FETCH);
      checkOutput("lw_retired", retired, 32'd1);

      // R-type with start dropped during REXEC
      tick(); checkState("r_decode", 4'h2, CTRL_DECODE);
      tick(); checkState("r_rexec", 4'h7, CTRL_REXEC);
      applyStimulus(1'b0, 1'b0, 6'b000000);
      tick(); checkState("r_rwb", 4'h8, CTRL_RWB);
      tick(); checkState("r_idle", 4'h0, CTRL_NONE);
      checkOutput("r_retired", retired, 32'd2);
      checkOutput("r_busy", {31'd0, busy}, 32'd0);

      // beq: 3-cycle instruction ending in IDLE
      applyStimulus(1'b0, 1'b1, 6'b000100);
      tick(); checkState("beq_fetch", 4'h1, CTRL_FETCH);
      tick(); checkState("beq_decode", 4'h2, CTRL_DECODE);
      applyStimulus(1'b0, 1'b0, 6'b000100);
      tick(); checkState("beq_branch", 4'hB, CTRL_BRANCH);
      tick(); checkState("beq_idle", 4'h0, CTRL_NONE);
      checkOutput("beq_retired", retired, 32'd3);

      // sw followed back-to-back by addi
      applyStimulus(1'b0, 1'b1, 6'b101011);
      tick(); checkState("sw_fetch", 4'h1, CTRL_FETCH);
      tick(); checkState("sw_decode", 4'h2, CTRL_DECODE);
      tick(); checkState("sw_memadr", 4'h3, CTRL_MEMADR);
      tick(); checkState("sw_memwr", 4'h6, CTRL_MEMWR);
      applyStimulus(1'b0, 1'b1, 6'b001000);
      tick(); checkState("addi_fetch", 4'h1, CTRL_FETCH);
      checkOutput("sw_retired", retired, 32'd4);
      tick(); checkState("addi_decode", 4'h2, CTRL_DECODE);
      tick(); checkState("addi_iexec", 4'h9, CTRL_IEXEC);
      applyStimulus(1'b0, 1'b0, 6'b001000);
      tick(); checkState("addi_iwb", 4'hA, CTRL_IWB);
      tick(); checkState("addi_idle", 4'h0, CTRL_NONE);
      checkOutput("addi_retired", retired, 32'd5);

      // Illegal opcode parks in ERROR regardless of start
      applyStimulus(1'b0, 1'b1, 6'b111111);
      tick(); checkState("bad_fetch", 4'h1, CTRL_FETCH);
      tick(); checkState("bad_decode", 4'h2, CTRL_DECODE);
      tick(); checkState("bad_error", 4'hF, CTRL_NONE);
      checkOutput("bad_err", {31'd0, err}, 32'd1);
      checkOutput("bad_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 1'b0, 6'b111111);
      tick(); checkState("bad_hold0", 4'hF, CTRL_NONE);
      applyStimulus(1'b0, 1'b1, 6'b000010);
      tick(); checkState("bad_hold1", 4'hF, CTRL_NONE);
      checkOutput("bad_retired", retired, 32'd5);
      applyStimulus(1'b1, 1'b1, 6'b000010);
      tick(); checkState("bad_reset", 4'h0, CTRL_NONE);
      checkOutput("bad_reset_err", {31'd0, err}, 32'd0);
      checkOutput("bad_reset_retired", retired, 32'd0);

      // Reset during MEMRD aborts the load
      applyStimulus(1'b0, 1'b1, 6'b100011);
      tick(); tick(); tick(); tick();
      checkState("rstmid_memrd", 4'h4, CTRL_MEMRD);
      applyStimulus(1'b1, 1'b1, 6'b100011);
      tick(); checkState("rstmid_idle", 4'h0, CTRL_NONE);
      checkOutput("rstmid_memread", {31'd0, MemRead}, 32'd0);
      checkOutput("rstmid_retired", retired, 32'd0);

      // Retire counter rollover on a jump
      applyStimulus(1'b0, 1'b0, 6'b000010);
      force dut.retired_q = 32'hFFFF_FFFF;
      tick();
      release dut.retired_q;
      checkOutput("wrap_preload", retired, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b1, 6'b000010);
      tick(); checkState("j_fetch", 4'h1, CTRL_FETCH);
      tick(); checkState("j_decode", 4'h2, CTRL_DECODE);
      applyStimulus(1'b0, 1'b0, 6'b000010);
      tick(); checkState("j_jump", 4'hC, CTRL_JUMP);
      checkOutput("j_retired_before", retired, 32'hFFFF_FFFF);
      tick(); checkState("j_idle", 4'h0, CTRL_NONE);
      checkOutput("wrap_retired", retired, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
